// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage is the master: it drives the address and request. Memory is
// the slave: it answers with ready and the instruction word.
interface fetch_unit_if;
    logic [31:0] IAddr;
    logic        IReq;
    logic        IReady;
    logic [31:0] IRData;

    modport master (
        output IAddr,
        output IReq,
        input  IReady,
        input  IRData
    );

    modport slave (
        input  IAddr,
        input  IReq,
        output IReady,
        output IRData
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the ARM core.
// This block holds the PC and fetches one word per instruction over a
// request/ready bus. It keeps the word in Instr and hands its decoded fields to
// the control unit. When the control unit reports the instruction complete, it
// moves the PC to PC+4 or to the branch target.
// Optional feature: define FETCH_TIMEOUT_EN to enable a fetch wait timeout.
// When enabled, a fetch that waits too long leaves a sticky fault in FetchFault
// and parks the unit in FAULT. Only Reset leaves FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    fetch_unit_if.master        imem,
    input  logic                ExecDone,
    input  logic                PCSrc,
    input  logic [31:0]         Result,
    output logic [31:0]         Instr,
    output logic [3:0]          Cond,
    output logic [1:0]          Op,
    output logic [5:0]          Funct,
    output logic [3:0]          Rn,
    output logic [3:0]          Rd,
    output logic [3:0]          Rm,
    output logic [23:0]         Imm24,
    output logic                InstrValid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus8,
    output logic [31:0]         RetiredCount,
    output logic                FetchFault
);

    // A timeout of zero cycles has no meaning, so reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

    // The PC is always word aligned, so drop any stray low bits of the reset vector.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;

    localparam int             WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;

    // State register. Reset aborts any fetch or instruction that is in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            wait_q    <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
`ifdef FETCH_TIMEOUT_EN
            wait_q    <= wait_d;
            fault_q   <= fault_d;
`endif
        end
    end

    // Next-state logic. Each state keeps its values unless it has a reason to change them.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
`ifdef FETCH_TIMEOUT_EN
        wait_d    = '0;
        fault_d   = fault_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem.IReady) begin
                    instr_d = imem.IRData;
                    state_d = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (ExecDone) begin
                    // Masking the whole word clears any misaligned target bits.
                    pc_d      = PCSrc ? (Result & 32'hFFFF_FFFC) : (pc_q + 32'd4);
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: begin
`ifdef FETCH_TIMEOUT_EN
                state_d = FAULT;
`else
                state_d = BOOT;
`endif
            end
        endcase
    end

    assign imem.IAddr   = pc_q;
    assign imem.IReq    = (state_q == FETCH);
    assign InstrValid   = (state_q == HOLD);
    assign PC           = pc_q;
    assign PCPlus8      = pc_q + 32'd8;
    assign RetiredCount = retired_q;
    assign Instr        = instr_q;
    assign Cond         = instr_q[31:28];
    assign Op           = instr_q[27:26];
    assign Funct        = instr_q[25:20];
    assign Rn           = instr_q[19:16];
    assign Rd           = instr_q[15:12];
    assign Rm           = instr_q[3:0];
    assign Imm24        = instr_q[23:0];
`ifdef FETCH_TIMEOUT_EN
    assign FetchFault   = fault_q;
`else
    assign FetchFault   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// dut0 starts at RESET_PC 0 and runs the main scenarios. dut1 starts at the
// top word of memory and covers PC wrap-around. When FETCH_TIMEOUT_EN is
// defined, dut1 also covers the fetch timeout with a limit of 4 cycles.
module tb_fetch_unit;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // ---------------- dut0 ----------------
    logic        rst0, done0, pcsrc0;
    logic [31:0] result0;
    logic [31:0] instr0, pc0, pc8_0, ret0;
    logic [3:0]  cond0, rn0, rd0, rm0;
    logic [1:0]  op0;
    logic [5:0]  funct0;
    logic [23:0] imm0;
    logic        valid0, fault0;
    fetch_unit_if imem0();

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut0 (
        .Clk(Clk), .Reset(rst0), .imem(imem0.master),
        .ExecDone(done0), .PCSrc(pcsrc0), .Result(result0),
        .Instr(instr0), .Cond(cond0), .Op(op0), .Funct(funct0),
        .Rn(rn0), .Rd(rd0), .Rm(rm0), .Imm24(imm0),
        .InstrValid(valid0), .PC(pc0), .PCPlus8(pc8_0),
        .RetiredCount(ret0), .FetchFault(fault0)
    );

    // ---------------- dut1 ----------------
    logic        rst1, done1, pcsrc1;
    logic [31:0] result1;
    logic [31:0] instr1, pc1, pc8_1, ret1;
    logic [3:0]  cond1, rn1, rd1, rm1;
    logic [1:0]  op1;
    logic [5:0]  funct1;
    logic [23:0] imm1;
    logic        valid1, fault1;
    fetch_unit_if imem1();

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(4)) dut1 (
        .Clk(Clk), .Reset(rst1), .imem(imem1.master),
        .ExecDone(done1), .PCSrc(pcsrc1), .Result(result1),
        .Instr(instr1), .Cond(cond1), .Op(op1), .Funct(funct1),
        .Rn(rn1), .Rd(rd1), .Rm(rm1), .Imm24(imm1),
        .InstrValid(valid1), .PC(pc1), .PCPlus8(pc8_1),
        .RetiredCount(ret1), .FetchFault(fault1)
    );

    // Advance one clock; inputs are driven and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; done0 = 1'b0; pcsrc0 = 1'b0; result0 = 32'h0;
        imem0.IReady = 1'b0; imem0.IRData = 32'h0;
        @(negedge Clk);
        tick(); tick();
        total++; if (imem0.IReq !== 1'b0) begin bad++; $display("FAIL reset_ireq got=%b exp=0", imem0.IReq); end
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid0); end
        total++; if (pc0 !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00000000", pc0); end
        total++; if (pc8_0 !== 32'h8) begin bad++; $display("FAIL reset_pcplus8 got=%h exp=00000008", pc8_0); end
        total++; if (ret0 !== 32'h0) begin bad++; $display("FAIL reset_retired got=%h exp=0", ret0); end
        total++; if (instr0 !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr0); end
        total++; if (fault0 !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault0); end
        $display("reset: pc=%h ireq=%b valid=%b", pc0, imem0.IReq, valid0);
        rst0 = 1'b0;
        tick();  // BOOT -> FETCH
    endtask

    // Two sequential instructions, then a branch with a misaligned target from PC=8.
    task automatic test_sequential_and_branch();
        imem0.IReady = 1'b1; imem0.IRData = 32'hE3A0_1005; done0 = 1'b1; pcsrc0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin pcsrc0 = 1'b1; result0 = 32'h0000_0103; end
            total++; if (imem0.IReq !== 1'b1) begin bad++; $display("FAIL seq_ireq[%0d] got=%b exp=1", i, imem0.IReq); end
            total++; if (imem0.IAddr !== 32'(4 * i)) begin bad++; $display("FAIL seq_iaddr[%0d] got=%h exp=%h", i, imem0.IAddr, 32'(4 * i)); end
            tick();
            total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, valid0); end
            total++; if ({cond0, op0, funct0, rn0, rd0, rm0} !== {4'hE, 2'b00, 6'b111010, 4'h0, 4'h1, 4'h5})
                begin bad++; $display("FAIL seq_fields[%0d] got=%h/%b/%b/%h/%h/%h", i, cond0, op0, funct0, rn0, rd0, rm0); end
            total++; if (imm0 !== 24'hA0_1005) begin bad++; $display("FAIL seq_imm24[%0d] got=%h exp=a01005", i, imm0); end
            total++; if (pc0 !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc0, 32'(4 * i)); end
            tick();
            $display("retire %0d: next iaddr=%h retired=%0d", i, imem0.IAddr, ret0);
        end
        total++; if (imem0.IAddr !== 32'h0000_0100) begin bad++; $display("FAIL branch_iaddr got=%h exp=00000100", imem0.IAddr); end
        total++; if (ret0 !== 32'd3) begin bad++; $display("FAIL branch_retired got=%0d exp=3", ret0); end
        total++; if (pc8_0 !== 32'h0000_0108) begin bad++; $display("FAIL branch_pcplus8 got=%h exp=00000108", pc8_0); end
        pcsrc0 = 1'b0;
    endtask

    // Five wait cycles at 0x100, then a load; IReady in HOLD must not reload Instr.
    task automatic test_wait_states();
        imem0.IReady = 1'b0; imem0.IRData = 32'hDEAD_BEEF; done0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (imem0.IAddr !== 32'h0000_0100 || imem0.IReq !== 1'b1)
                begin bad++; $display("FAIL wait_addr[%0d] got=%h/%b exp=00000100/1", i, imem0.IAddr, imem0.IReq); end
            total++; if (instr0 !== 32'hE3A0_1005 || valid0 !== 1'b0)
                begin bad++; $display("FAIL wait_instr[%0d] got=%h/%b exp=e3a01005/0", i, instr0, valid0); end
            tick();
        end
        imem0.IReady = 1'b1; imem0.IRData = 32'h1234_5678;
        tick();
        total++; if (valid0 !== 1'b1 || instr0 !== 32'h1234_5678)
            begin bad++; $display("FAIL wait_load got=%h/%b exp=12345678/1", instr0, valid0); end
        total++; if (cond0 !== 4'h1 || rm0 !== 4'h8) begin bad++; $display("FAIL wait_fields got=%h/%h exp=1/8", cond0, rm0); end
        imem0.IRData = 32'hFFFF_FFFF;
        tick();
        total++; if (instr0 !== 32'h1234_5678 || imem0.IReq !== 1'b0 || pc0 !== 32'h100)
            begin bad++; $display("FAIL hold_stable got=%h/%b/%h exp=12345678/0/00000100", instr0, imem0.IReq, pc0); end
        $display("wait: loaded instr=%h at pc=%h", instr0, pc0);
    endtask

    // Reset during HOLD with ExecDone high: nothing retires, and the unit restarts.
    task automatic test_reset_in_hold();
        rst0 = 1'b1; done0 = 1'b1;
        tick();
        total++; if (pc0 !== 32'h0) begin bad++; $display("FAIL rsthold_pc got=%h exp=0", pc0); end
        total++; if (valid0 !== 1'b0 || imem0.IReq !== 1'b0)
            begin bad++; $display("FAIL rsthold_outs got=%b/%b exp=0/0", valid0, imem0.IReq); end
        total++; if (ret0 !== 32'h0) begin bad++; $display("FAIL rsthold_retired got=%0d exp=0", ret0); end
        rst0 = 1'b0; done0 = 1'b0;
        tick();
        total++; if (imem0.IReq !== 1'b1) begin bad++; $display("FAIL rsthold_refetch got=%b exp=1", imem0.IReq); end
        $display("reset in hold: pc=%h retired=%0d", pc0, ret0);
    endtask

    // Reset vector at the top word: PC+8 and PC+4 both wrap to low memory.
    task automatic test_pc_wrap();
        rst1 = 1'b1; done1 = 1'b1; pcsrc1 = 1'b0; result1 = 32'h0;
        imem1.IReady = 1'b1; imem1.IRData = 32'hE1A0_0000;
        tick();
        total++; if (pc8_1 !== 32'h0000_0004 || imem1.IAddr !== 32'hFFFF_FFFC)
            begin bad++; $display("FAIL wrap_reset got=%h/%h exp=00000004/fffffffc", pc8_1, imem1.IAddr); end
        rst1 = 1'b0;
        tick(); tick(); tick();  // BOOT, FETCH, HOLD(retire)
        total++; if (imem1.IAddr !== 32'h0 || ret1 !== 32'd1 || imem1.IReq !== 1'b1)
            begin bad++; $display("FAIL wrap_next got=%h/%0d/%b exp=00000000/1/1", imem1.IAddr, ret1, imem1.IReq); end
        $display("wrap: next iaddr=%h retired=%0d", imem1.IAddr, ret1);
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        rst1 = 1'b1; done1 = 1'b0; imem1.IReady = 1'b0;
        tick();
        rst1 = 1'b0;
        tick();  // BOOT -> FETCH
        for (int i = 0; i < 4; i++) begin
            total++; if (imem1.IReq !== 1'b1 || fault1 !== 1'b0)
                begin bad++; $display("FAIL to_wait[%0d] got=%b/%b exp=1/0", i, imem1.IReq, fault1); end
            tick();
        end
        total++; if (fault1 !== 1'b1 || imem1.IReq !== 1'b0)
            begin bad++; $display("FAIL to_fault got=%b/%b exp=1/0", fault1, imem1.IReq); end
        imem1.IReady = 1'b1;
        tick(); tick();
        total++; if (fault1 !== 1'b1 || imem1.IReq !== 1'b0 || valid1 !== 1'b0)
            begin bad++; $display("FAIL to_sticky got=%b/%b/%b exp=1/0/0", fault1, imem1.IReq, valid1); end
        rst1 = 1'b1;
        tick();
        total++; if (fault1 !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", fault1); end
        rst1 = 1'b0;
        $display("timeout: fault cleared by reset");
    endtask
`endif

    initial begin
        rst1 = 1'b1; done1 = 1'b0; pcsrc1 = 1'b0; result1 = 32'h0;
        imem1.IReady = 1'b0; imem1.IRData = 32'h0;
        test_reset();
        test_sequential_and_branch();
        test_wait_states();
        test_reset_in_hold();
        test_pc_wrap();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the ARM core. Holds the program counter, runs a request/ready handshake with instruction memory, and latches the returned word into an instruction register. It presents the decoded fields (Cond, Op, Funct, Rd, Rn, Rm, Imm24) directly to the control unit. It consumes the control unit's PCSrc and the datapath's Result to select the next PC when the current instruction completes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
- TIMEOUT_CYCLES, 16, max FETCH wait cycles before fault (used only with the timeout feature)

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- IAddr  out  32  instruction memory address (= PC)
- IReq  out  1  fetch request
- IReady  in  1  memory has valid data on IRData this cycle
- IRData  in  32  instruction word from memory
- ExecDone  in  1  current instruction finished; advance PC
- PCSrc  in  1  from control unit; 1 = take Result as next PC
- Result  in  32  branch/PC-write target from datapath
- Instr  out  32  instruction register
- Cond  out  4  Instr[31:28]
- Op  out  2  Instr[27:26]
- Funct  out  6  Instr[25:20]
- Rn  out  4  Instr[19:16]
- Rd  out  4  Instr[15:12]
- Rm  out  4  Instr[3:0]
- Imm24  out  24  Instr[23:0]
- InstrValid  out  1  Instr holds a fetched, not-yet-completed instruction
- PC  out  32  address of the instruction in Instr
- PCPlus8  out  32  PC + 8, the architectural read value of R15
- RetiredCount  out  32  number of completed instructions
- FetchFault  out  1  sticky timeout fault

## Operation
- States: BOOT, FETCH, HOLD, FAULT. Moore outputs: IReq = (state==FETCH), InstrValid = (state==HOLD).
- Reset (any state, any cycle): state=BOOT, PC=RESET_PC, Instr=0, RetiredCount=0, FetchFault=0, wait counter=0. Resulting outputs: IReq=0, InstrValid=0.
- BOOT -> FETCH unconditionally on the next cycle.
- FETCH: drive IAddr=PC with IReq=1.
  - IReady=1: Instr<=IRData, state->HOLD.
  - IReady=0: remain in FETCH.
  - IRData is sampled only when IReq&IReady.
- HOLD: Instr and PC are stable.
  - On ExecDone=1: PC<=PCSrc ? {Result[31:2],2'b00} : PC+4; RetiredCount++; state->FETCH.
- ExecDone and PCSrc are ignored outside HOLD.
- Arithmetic:
  - PC+4 and PCPlus8 wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - RetiredCount wraps modulo 2^32.
  - A misaligned branch target has its low 2 bits silently cleared.
- IReady asserted in BOOT/HOLD/FAULT has no effect.
- Field outputs are pure slices of Instr, so they change only when Instr loads.

## Timing
- Fetch latency: the cycle after IReq&IReady, InstrValid=1 and the fields are valid. Minimum is 1 FETCH cycle per instruction.
- Throughput: best case 2 cycles per instruction (FETCH, HOLD with ExecDone=1).
- IAddr changes only on the edge that leaves HOLD. It is stable for the whole FETCH wait.
- Reset asserted mid-FETCH or mid-HOLD aborts that fetch or instruction.
  - The next cycle shows IReq=0, InstrValid=0, PC=RESET_PC.
  - RetiredCount does not increment, even if ExecDone was also high.
- PCPlus8 is combinational from PC, so it is valid in the same cycle as PC.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter increments each FETCH cycle with IReady=0 and clears on leaving FETCH.
  - After TIMEOUT_CYCLES consecutive wait cycles, the next edge sets FetchFault=1 and state->FAULT.
  - FAULT holds IReq=0 and InstrValid=0 and is exited only by Reset.
- FETCH_TIMEOUT_EN undefined: no counter, no FAULT state, FetchFault tied 0, and FETCH waits indefinitely.

## Test plan
- Reset, then IReady=1 every cycle, IRData=32'hE3A01005, ExecDone=1 in each HOLD, PCSrc=0 -> IAddr sequence 0,4,8,...; Cond=4'hE, Op=2'b00, Funct=6'b111010, Rd=4'h1; RetiredCount=3 after three HOLD cycles.
- In HOLD at PC=8, PCSrc=1, Result=32'h0000_0103, ExecDone=1 -> next IAddr=32'h0000_0100; RetiredCount increments.
- Hold IReady=0 for 5 FETCH cycles, then 1 -> IAddr stable throughout; Instr loads only on the 6th cycle; InstrValid rises the next cycle.
- RESET_PC=32'hFFFF_FFFC, one sequential instruction retires -> next IAddr=0; PCPlus8 at reset = 32'h0000_0004.
- Assert Reset during HOLD together with ExecDone=1 -> next cycle PC=RESET_PC, InstrValid=0, RetiredCount=0, IReq=0; one cycle later IReq=1.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, hold IReady=0 -> FetchFault=1 and IReq=0 after 4 wait cycles; a later IReady=1 is ignored; Reset clears FetchFault.
